// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: buffers committed-instruction trace entries and serialises them into 32-bit beats.
// COMMIT_TRACE_TIMESTAMP_EN adds a capture timestamp as a fourth beat.
module commit_trace_buffer #(
  parameter int p_depth = 8,
  parameter int p_cnt_bits = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trace_val,
  input  logic [31:0]             trace_pc,
  input  logic [4:0]              trace_waddr,
  input  logic [31:0]             trace_wdata,
  input  logic                    trace_wen,
  output logic [31:0]             out_msg,
  output logic                    out_last,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [p_cnt_bits-1:0]   drop_count,
  output logic [$clog2(p_depth):0] occupancy
);
  localparam int AW = $clog2(p_depth);
  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} state_t;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  localparam state_t S_LAST = S_B3;
`else
  localparam state_t S_LAST = S_B2;
`endif
  state_t state_q, state_d;
  logic [AW:0] wptr_q, rptr_q;
  logic [p_cnt_bits-1:0] drop_q;
  logic [31:0] pc_m [p_depth];
  logic [31:0] wdata_m [p_depth];
  logic [4:0] waddr_m [p_depth];
  logic wen_m [p_depth];
  logic [AW-1:0] head;
  logic [31:0] ts_head;
  logic full, rel, push, drop, more;
  assign head = rptr_q[AW-1:0];
  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign occupancy = wptr_q - rptr_q;
  assign drop_count = drop_q;
  assign out_val = state_q != S_IDLE;
  assign out_last = state_q == S_LAST;
  assign rel = out_val && out_rdy && out_last;
  // a last-beat handshake frees the head slot in time for a same-cycle capture
  assign push = trace_val && (!full || rel);
  assign drop = trace_val && !push;
  assign more = (occupancy != (AW+1)'(1)) || push;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_m [p_depth];
  always_ff @(posedge clk or posedge rst)
    if (rst) ts_q <= '0;
    else ts_q <= ts_q + 32'd1;
  always_ff @(posedge clk)
    if (push) ts_m[wptr_q[AW-1:0]] <= ts_q;
  assign ts_head = ts_m[head];
`else
  assign ts_head = '0;
`endif
  always_ff @(posedge clk)
    if (push) begin
      pc_m[wptr_q[AW-1:0]] <= trace_pc;
      wdata_m[wptr_q[AW-1:0]] <= trace_wdata;
      waddr_m[wptr_q[AW-1:0]] <= trace_waddr;
      wen_m[wptr_q[AW-1:0]] <= trace_wen;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_q + (AW+1)'(push);
      rptr_q <= rptr_q + (AW+1)'(rel);
      if (drop && !(&drop_q)) drop_q <= drop_q + 1'b1;
    end
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) state_d = push ? S_B0 : S_IDLE;
    else if (out_rdy) state_d = out_last ? (more ? S_B0 : S_IDLE) : state_t'(state_q + 3'd1);
  end
  always_comb
    out_msg = state_q == S_B0 ? pc_m[head] :
              state_q == S_B1 ? {wen_m[head], 26'b0, waddr_m[head]} :
              state_q == S_B2 ? wdata_m[head] :
              state_q == S_B3 ? ts_head : 32'b0;
endmodule
